// File: rtl/inv_subcells_serial_pkg.sv
// inv_subcells_serial_pkg: shared constants, FSM encoding and S-box helpers for QARMAv2 serial blocks
// Provides STATE_W/NIBBLE_W/NIBBLES, fsm_t {IDLE, RUN, DONE}, calc_n(lanes) and inv_sbox(nibble).
package inv_subcells_serial_pkg;
    localparam int STATE_W  = 128;
    localparam int NIBBLE_W = 4;
    localparam int NIBBLES  = 32;
    // QARMAv2 inverse S-box, entry i sits at bits [4i+3:4i]
    localparam logic [63:0] INV_SBOX = 64'h76B43F2C1590DEA8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
    function automatic int calc_n(input int lanes);
        return lanes > 0 ? NIBBLES / lanes : 1;
    endfunction
    function automatic logic [NIBBLE_W-1:0] inv_sbox(input logic [NIBBLE_W-1:0] x);
        return INV_SBOX[{x, 2'b00} +: NIBBLE_W];
    endfunction
endpackage

// File: rtl/inv_subcells_serial_lanes.sv
// inv_sbox_lanes: bank of LANES parallel QARMAv2 inverse S-boxes
// Ports: i_nib - LANES input nibbles, o_nib - LANES substituted nibbles (same positions).
module inv_sbox_lanes
    import inv_subcells_serial_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic [NIBBLE_W*LANES-1:0] i_nib,
    output logic [NIBBLE_W*LANES-1:0] o_nib
);
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign o_nib[NIBBLE_W*g +: NIBBLE_W] = inv_sbox(i_nib[NIBBLE_W*g +: NIBBLE_W]);
    end
endmodule

// File: rtl/inv_subcells_serial.sv
// inv_subcells_serial: multi-cycle inverse SubCells over the 128-bit QARMAv2 state, LANES nibbles per cycle
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data accept a state;
// out_valid/out_ready/out_data return the result; busy is high while an operation is in RUN or DONE.
module inv_subcells_serial
    import inv_subcells_serial_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);
    localparam int N  = calc_n(LANES);
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam int LW = NIBBLE_W * LANES;

    if (LANES < 1 || LANES > NIBBLES || NIBBLES % LANES != 0) begin : g_bad_lanes
        $error("inv_subcells_serial: LANES must divide 32");
    end

    fsm_t               r_fsm;
    logic [STATE_W-1:0] r_state;
    logic [CW-1:0]      r_cnt;
    logic [LW-1:0]      w_sub;
    logic [STATE_W-1:0] w_next;
    logic               w_last;

    inv_sbox_lanes #(.LANES(LANES)) u_lanes (
        .i_nib(r_state[LW-1:0]),
        .o_nib(w_sub)
    );

    // Rotate right by one lane group; substituted nibbles re-enter at the top so
    // after N steps every nibble is back in its original position.
    if (LANES == NIBBLES) begin : g_full
        assign w_next = w_sub;
    end else begin : g_part
        assign w_next = {w_sub, r_state[STATE_W-1:LW]};
    end

    assign w_last    = r_cnt == CW'(N - 1);
    assign in_ready  = r_fsm == IDLE;
    assign out_valid = r_fsm == DONE;
    assign busy      = !in_ready;
    assign out_data  = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_fsm)
                IDLE: if (in_valid) begin
                    r_state <= in_data;
                    r_cnt   <= '0;
                    r_fsm   <= RUN;
                end
                RUN: begin
                    r_state <= w_next;
                    r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                    if (w_last) r_fsm <= DONE;
                end
                DONE: if (out_ready) r_fsm <= IDLE;
                default: r_fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_subcells_serial.sv
// tb_inv_subcells_serial: self-checking bench for inv_subcells_serial with LANES = 1, 4 and 32
module tb_inv_subcells_serial;
    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];
    int n_cmp = 0;
    int n_err = 0;
    // forward QARMAv2 S-box; the bench derives everything from this table
    int sbox [16] = '{4, 7, 9, 11, 12, 6, 14, 15, 0, 5, 1, 13, 8, 3, 2, 10};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_subcells_serial #(.LANES(g == 0 ? 1 : g == 1 ? 4 : 32)) dut (
            .clk(clk), .rst_n(rst_n),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]), .in_data(in_data[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
            .busy(busy[g])
        );
    end

    function automatic int nlat(input int d);
        return d == 0 ? 32 : d == 1 ? 8 : 1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] subcells(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 32; i++) r[4*i +: 4] = 4'(sbox[x[4*i +: 4]]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic accept(input int d, input logic [127:0] din);
        @(negedge clk);
        in_valid[d] = 1;
        in_data[d]  = din;
        @(posedge clk); #1;
        in_valid[d] = 0;
        in_data[d]  = rnd128();
    endtask

    task automatic wait_done(input int d, output int lat);
        lat = 0;
        while (!out_valid[d] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input int d, input logic [127:0] din, input logic [127:0] exp, input string tag);
        int lat;
        accept(d, din);
        wait_done(d, lat);
        check({tag, " latency"}, 128'(lat), 128'(nlat(d)));
        check({tag, " data"}, out_data[d], exp);
        @(negedge clk);
        out_ready[d] = 1;
        @(posedge clk); #1;
        out_ready[d] = 0;
        check({tag, " release"}, {126'd0, out_valid[d], in_ready[d]}, 128'b01);
    endtask

    initial begin
        logic [127:0] x, y;
        int lat, seen;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 0; out_ready[i] = 0; in_data[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset in_ready", {127'd0, in_ready[1]}, 128'd1);
        check("reset out_valid", {127'd0, out_valid[1]}, 128'd0);
        check("reset busy", {127'd0, busy[1]}, 128'd0);
        check("reset out_data", out_data[1], 128'd0);
        rst_n = 1;

        run_op(1, 128'd0, {32{4'h8}}, "zeros");
        run_op(1, 128'h4, {{31{4'h8}}, 4'h0}, "nibble0");
        run_op(1, {4'h4, 124'd0}, {4'h0, {31{4'h8}}}, "nibble31");
        x = 128'h0123456789abcdeffedcba9876543210;
        for (int d = 0; d < 3; d++) run_op(d, subcells(x), x, $sformatf("roundtrip L%0d", d));

        // backpressure: result held, no second accept while DONE
        x = rnd128();
        y = rnd128();
        accept(1, subcells(x));
        wait_done(1, lat);
        @(negedge clk);
        in_valid[1] = 1;
        in_data[1]  = subcells(y);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp out_valid", {127'd0, out_valid[1]}, 128'd1);
            check("bp in_ready", {127'd0, in_ready[1]}, 128'd0);
            check("bp out_data", out_data[1], x);
        end
        @(negedge clk);
        out_ready[1] = 1;
        @(posedge clk); #1;
        out_ready[1] = 0;
        check("bp idle", {126'd0, out_valid[1], in_ready[1]}, 128'b01);
        @(posedge clk); #1;
        in_valid[1] = 0;
        check("bp second accept", {126'd0, busy[1], in_ready[1]}, 128'b10);
        wait_done(1, lat);
        check("bp second latency", 128'(lat), 128'd8);
        check("bp second data", out_data[1], y);
        @(negedge clk);
        out_ready[1] = 1;
        @(negedge clk);
        out_ready[1] = 0;

        // asynchronous reset while RUN at cnt==3
        accept(1, rnd128());
        repeat (2) @(posedge clk);
        @(posedge clk); #3;
        rst_n = 0;
        #1;
        check("async rst in_ready", {127'd0, in_ready[1]}, 128'd1);
        check("async rst out_valid", {127'd0, out_valid[1]}, 128'd0);
        check("async rst busy", {127'd0, busy[1]}, 128'd0);
        check("async rst out_data", out_data[1], 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid[1]) seen++;
        end
        check("aborted op silent", 128'(seen), 128'd0);
        run_op(1, 128'd0, {32{4'h8}}, "post-reset zeros");

        // randomized round trips on all lane counts concurrently
        fork
            begin
                logic [127:0] r0;
                for (int i = 0; i < 1000; i++) begin r0 = rnd128(); run_op(0, subcells(r0), r0, "rand L1"); end
            end
            begin
                logic [127:0] r1;
                for (int i = 0; i < 1000; i++) begin r1 = rnd128(); run_op(1, subcells(r1), r1, "rand L4"); end
            end
            begin
                logic [127:0] r2;
                for (int i = 0; i < 1000; i++) begin r2 = rnd128(); run_op(2, subcells(r2), r2, "rand L32"); end
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
